// File: rtl/datapath_pkg.sv
// Shared types for the parametrised datapath: bus source encoding, ALU opcodes, flag bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package datapath_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OVR  = 2'd1,
    ALU  = 2'd2,
    REG  = 2'd3
  } bus_src_t;

  typedef enum logic [2:0] {
    ADD   = 3'd0,
    SUB   = 3'd1,
    AND   = 3'd2,
    OR    = 3'd3,
    XOR   = 3'd4,
    SHL   = 3'd5,
    SHR   = 3'd6,
    PASSB = 3'd7
  } alu_op_t;

  // Bit positions inside the packed 4-bit flag vector.
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

endpackage

// File: rtl/datapath_param_alu_seq.sv
// Sequential ALU: operand latch, bit-serial shifter, result register and N/Z/C/V flag register.
// Latency: 1 cycle for logic/arith ops and shifts of 0 or 1; k cycles for a shift by k (busy for k-1).
// Backpressure: start is ignored while busy; done pulses for one cycle when the result lands.
// Ports: clk, rst_n (sync, active-low), a/b operands, op, shift_amt, flag_wr, start in;
//        result, flags, busy, done out.
module alu_seq
  import datapath_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  alu_op_t                    op,
  input  logic [$clog2(WIDTH)-1:0]   shift_amt,
  input  logic                       flag_wr,
  input  logic                       start,
  output logic [WIDTH-1:0]           result,
  output logic [3:0]                 flags,
  output logic                       busy,
  output logic                       done
);

  localparam int AMT_W = $clog2(WIDTH);
  localparam int MSB   = WIDTH - 1;

  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sh_q;      // working copy of A while a multi-cycle shift runs
  logic [AMT_W-1:0] cnt_q;     // shift steps still to perform, including the current one
  logic             shl_q;
  logic             fw_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       flags_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] comb_res;
  logic             comb_c;
  logic             comb_v;
  logic             is_multi;

  logic [WIDTH-1:0] step_in;
  logic             step_left;
  logic [WIDTH-1:0] step_out;
  logic             step_c;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = r[MSB];
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  // Single-cycle evaluation; shifts by 0 fall into the default (result A, C=0).
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    comb_res = a;
    comb_c   = 1'b0;
    comb_v   = 1'b0;
    case (op)
      ADD: begin
        comb_res = sum[MSB:0];
        comb_c   = sum[WIDTH];
        comb_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      SUB: begin
        comb_res = diff[MSB:0];
        comb_c   = ~diff[WIDTH];  // carry means "no borrow"
        comb_v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      AND:     comb_res = a & b;
      OR:      comb_res = a | b;
      XOR:     comb_res = a ^ b;
      PASSB:   comb_res = b;
      default: comb_res = a;
    endcase
  end

  assign is_multi = ((op == SHL) || (op == SHR)) && (shift_amt != '0);

  // One shift step: from the live operand on the accepting edge, from sh_q afterwards.
  always_comb begin
    step_in   = busy_q ? sh_q : a;
    step_left = busy_q ? shl_q : (op == SHL);
    step_out  = step_left ? {step_in[MSB-1:0], 1'b0} : {1'b0, step_in[MSB:1]};
    step_c    = step_left ? step_in[MSB] : step_in[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      shl_q   <= 1'b0;
      fw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        sh_q  <= step_out;
        cnt_q <= cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          res_q  <= step_out;
          if (fw_q) flags_q <= mk_flags(step_out, step_c, 1'b0);
        end
      end else if (start) begin
        if (is_multi) begin
          if (shift_amt == AMT_W'(1)) begin
            // A single step finishes on the accepting edge, so busy never rises.
            done_q <= 1'b1;
            res_q  <= step_out;
            if (flag_wr) flags_q <= mk_flags(step_out, step_c, 1'b0);
          end else begin
            busy_q <= 1'b1;
            sh_q   <= step_out;
            cnt_q  <= shift_amt - AMT_W'(1);
            shl_q  <= (op == SHL);
            fw_q   <= flag_wr;
          end
        end else begin
          done_q <= 1'b1;
          res_q  <= comb_res;
          if (flag_wr) flags_q <= mk_flags(comb_res, comb_c, comb_v);
        end
      end
    end
  end

  assign result = res_q;
  assign flags  = flags_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: rtl/datapath_param.sv
// Parametrised datapath: NUM_REGS x WIDTH register file, sequential ALU, one encoded-select shared bus.
// Latency: bus is combinational; register writes land at the next edge; ALU timing as in alu_seq.
// Backpressure: ALU starts are dropped while o_aluBusy=1; the control unit must wait for o_aluDone.
// Ports: i_clk, i_reset (sync, active-low), i_busOverride, i_ctrl* control inputs;
//        o_bus, o_aluBusy, o_aluDone, o_aluFlag{N,Z,C,V} outputs.
module datapath_param
  import datapath_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [WIDTH-1:0]             i_busOverride,
  input  logic [1:0]                   i_ctrlBusSrc,
  input  logic                         i_ctrlRegWr,
  input  logic [$clog2(NUM_REGS)-1:0]  i_ctrlRegWrSel,
  input  logic [$clog2(NUM_REGS)-1:0]  i_ctrlRegBusSel,
  input  logic [$clog2(NUM_REGS)-1:0]  i_ctrlAluSel,
  input  logic [2:0]                   i_ctrlAluOp,
  input  logic                         i_ctrlAluStart,
  input  logic [$clog2(WIDTH)-1:0]     i_ctrlShiftAmt,
  input  logic                         i_ctrlFlagWr,
  output logic [WIDTH-1:0]             o_bus,
  output logic                         o_aluBusy,
  output logic                         o_aluDone,
  output logic                         o_aluFlagN,
  output logic                         o_aluFlagZ,
  output logic                         o_aluFlagC,
  output logic                         o_aluFlagV
);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       flags;

  // Single encoded select: exactly one source can ever drive the bus.
  always_comb begin
    case (bus_src_t'(i_ctrlBusSrc))
      NONE:    o_bus = '0;
      OVR:     o_bus = i_busOverride;
      ALU:     o_bus = alu_result;
      REG:     o_bus = regs[i_ctrlRegBusSel];
      default: o_bus = '0;
    endcase
  end

  // Reads are combinational from the array, so a write in the same cycle is seen only after the edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (i_ctrlRegWr) begin
      regs[i_ctrlRegWrSel] <= o_bus;
    end
  end

  alu_seq #(.WIDTH(WIDTH)) u_alu (
    .clk       (i_clk),
    .rst_n     (i_reset),
    .a         (regs[i_ctrlAluSel]),
    .b         (o_bus),
    .op        (alu_op_t'(i_ctrlAluOp)),
    .shift_amt (i_ctrlShiftAmt),
    .flag_wr   (i_ctrlFlagWr),
    .start     (i_ctrlAluStart),
    .result    (alu_result),
    .flags     (flags),
    .busy      (o_aluBusy),
    .done      (o_aluDone)
  );

  assign o_aluFlagN = flags[FLAG_N];
  assign o_aluFlagZ = flags[FLAG_Z];
  assign o_aluFlagC = flags[FLAG_C];
  assign o_aluFlagV = flags[FLAG_V];

endmodule

// File: tb/tb_datapath_param.sv
// Directed bench for datapath_param (WIDTH=8, NUM_REGS=4) with hand-computed expected values.
// Inputs change 1 ns after a rising edge; outputs are sampled 1-2 ns after the edge.
module tb_datapath_param;
  import datapath_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_busOverride;
  logic [1:0] i_ctrlBusSrc;
  logic       i_ctrlRegWr;
  logic [1:0] i_ctrlRegWrSel;
  logic [1:0] i_ctrlRegBusSel;
  logic [1:0] i_ctrlAluSel;
  logic [2:0] i_ctrlAluOp;
  logic       i_ctrlAluStart;
  logic [2:0] i_ctrlShiftAmt;
  logic       i_ctrlFlagWr;
  logic [7:0] o_bus;
  logic       o_aluBusy;
  logic       o_aluDone;
  logic       o_aluFlagN;
  logic       o_aluFlagZ;
  logic       o_aluFlagC;
  logic       o_aluFlagV;

  int n_checks = 0;
  int n_fail   = 0;

  datapath_param #(.WIDTH(8), .NUM_REGS(4)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_busOverride   (i_busOverride),
    .i_ctrlBusSrc    (i_ctrlBusSrc),
    .i_ctrlRegWr     (i_ctrlRegWr),
    .i_ctrlRegWrSel  (i_ctrlRegWrSel),
    .i_ctrlRegBusSel (i_ctrlRegBusSel),
    .i_ctrlAluSel    (i_ctrlAluSel),
    .i_ctrlAluOp     (i_ctrlAluOp),
    .i_ctrlAluStart  (i_ctrlAluStart),
    .i_ctrlShiftAmt  (i_ctrlShiftAmt),
    .i_ctrlFlagWr    (i_ctrlFlagWr),
    .o_bus           (o_bus),
    .o_aluBusy       (o_aluBusy),
    .o_aluDone       (o_aluDone),
    .o_aluFlagN      (o_aluFlagN),
    .o_aluFlagZ      (o_aluFlagZ),
    .o_aluFlagC      (o_aluFlagC),
    .o_aluFlagV      (o_aluFlagV)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_busOverride   = '0;
    i_ctrlBusSrc    = NONE;
    i_ctrlRegWr     = 1'b0;
    i_ctrlRegWrSel  = '0;
    i_ctrlRegBusSel = '0;
    i_ctrlAluSel    = '0;
    i_ctrlAluOp     = ADD;
    i_ctrlAluStart  = 1'b0;
    i_ctrlShiftAmt  = '0;
    i_ctrlFlagWr    = 1'b0;
  endtask

  task automatic write_reg(input logic [1:0] idx, input logic [7:0] val);
    i_ctrlBusSrc   = OVR;
    i_busOverride  = val;
    i_ctrlRegWr    = 1'b1;
    i_ctrlRegWrSel = idx;
    cyc();
    i_ctrlRegWr    = 1'b0;
  endtask

  // Issue a one-cycle start pulse; B comes from the override bus.
  task automatic start_op(input logic [2:0] op, input logic [1:0] asel, input logic [7:0] bval,
                          input logic [2:0] amt, input logic fw);
    i_ctrlBusSrc   = OVR;
    i_busOverride  = bval;
    i_ctrlAluSel   = asel;
    i_ctrlAluOp    = op;
    i_ctrlShiftAmt = amt;
    i_ctrlFlagWr   = fw;
    i_ctrlAluStart = 1'b1;
    cyc();
    i_ctrlAluStart = 1'b0;
  endtask

  function automatic logic [3:0] nzcv();
    return {o_aluFlagN, o_aluFlagZ, o_aluFlagC, o_aluFlagV};
  endfunction

  task automatic check_result(input string tag, input logic [7:0] exp);
    i_ctrlBusSrc = ALU;
    #1;
    check(tag, o_bus, exp);
  endtask

  initial begin
    idle();
    i_reset = 1'b0;
    cyc();
    i_reset = 1'b1;

    // Random activity, then a two-cycle reset.
    for (int i = 0; i < 12; i++) begin
      i_busOverride   = 8'($urandom);
      i_ctrlBusSrc    = 2'($urandom);
      i_ctrlRegWr     = 1'($urandom);
      i_ctrlRegWrSel  = 2'($urandom);
      i_ctrlRegBusSel = 2'($urandom);
      i_ctrlAluSel    = 2'($urandom);
      i_ctrlAluOp     = 3'($urandom);
      i_ctrlAluStart  = 1'($urandom);
      i_ctrlShiftAmt  = 3'($urandom);
      i_ctrlFlagWr    = 1'b1;
      cyc();
    end
    i_reset = 1'b0;
    cyc();
    cyc();
    i_reset = 1'b1;
    idle();
    #1;
    check("rst_bus_none", o_bus, 8'h00);
    check("rst_busy", o_aluBusy, 1'b0);
    check("rst_done", o_aluDone, 1'b0);
    check("rst_flags", nzcv(), 4'b0000);
    i_ctrlBusSrc = REG;
    for (int r = 0; r < 4; r++) begin
      i_ctrlRegBusSel = 2'(r);
      #1;
      check($sformatf("rst_reg%0d", r), o_bus, 8'h00);
    end
    check_result("rst_result", 8'h00);

    // ADD overflow: 0x7F + 0x01.
    write_reg(2'd0, 8'h7F);
    start_op(ADD, 2'd0, 8'h01, 3'd0, 1'b1);
    check("add_done", o_aluDone, 1'b1);
    check("add_busy", o_aluBusy, 1'b0);
    check("add_flags", nzcv(), 4'b1001);
    check_result("add_result", 8'h80);
    cyc();
    check("add_done_drop", o_aluDone, 1'b0);

    // SUB equal: 5 - 5.
    write_reg(2'd1, 8'h05);
    start_op(SUB, 2'd1, 8'h05, 3'd0, 1'b1);
    check("sub_eq_done", o_aluDone, 1'b1);
    check("sub_eq_flags", nzcv(), 4'b0110);
    check_result("sub_eq_result", 8'h00);

    // 5 - 7 with flag write off: result updates, flags hold.
    start_op(SUB, 2'd1, 8'h07, 3'd0, 1'b0);
    check("sub_nofw_done", o_aluDone, 1'b1);
    check("sub_nofw_flags", nzcv(), 4'b0110);
    check_result("sub_nofw_result", 8'hFE);

    // SHL by 3 of 0xA1 with an ignored start while busy and a start in the done cycle.
    write_reg(2'd2, 8'hA1);
    start_op(SHL, 2'd2, 8'h00, 3'd3, 1'b1);
    check("shl_busy1", o_aluBusy, 1'b1);
    check("shl_nodone1", o_aluDone, 1'b0);
    check_result("shl_hold", 8'hFE);
    start_op(ADD, 2'd0, 8'h01, 3'd0, 1'b1);   // must be ignored
    check("shl_busy2", o_aluBusy, 1'b1);
    check("shl_nodone2", o_aluDone, 1'b0);
    check_result("shl_hold2", 8'hFE);
    cyc();
    check("shl_done", o_aluDone, 1'b1);
    check("shl_busy_low", o_aluBusy, 1'b0);
    check("shl_flags", nzcv(), 4'b0010);
    check_result("shl_result", 8'h08);
    start_op(AND, 2'd0, 8'h0F, 3'd0, 1'b1);   // accepted in the done cycle
    check("b2b_done", o_aluDone, 1'b1);
    check("b2b_flags", nzcv(), 4'b0000);
    check_result("b2b_result", 8'h0F);

    // SHR by 1 completes in a single cycle: 0xA1 >> 1 = 0x50, C = 1.
    start_op(SHR, 2'd2, 8'h00, 3'd1, 1'b1);
    check("shr1_done", o_aluDone, 1'b1);
    check("shr1_busy", o_aluBusy, 1'b0);
    check("shr1_flags", nzcv(), 4'b0010);
    check_result("shr1_result", 8'h50);

    // Reset in the middle of SHR by 7 of 0xFF.
    write_reg(2'd3, 8'hFF);
    start_op(SHR, 2'd3, 8'h00, 3'd7, 1'b1);
    check("rmid_busy1", o_aluBusy, 1'b1);
    cyc();
    cyc();
    check("rmid_busy3", o_aluBusy, 1'b1);
    i_reset = 1'b0;
    cyc();
    i_reset = 1'b1;
    check("rmid_busy", o_aluBusy, 1'b0);
    check("rmid_done", o_aluDone, 1'b0);
    check("rmid_flags", nzcv(), 4'b0000);
    check_result("rmid_result", 8'h00);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check($sformatf("rmid_nodone%0d", i), o_aluDone, 1'b0);
    end

    // Bus write-through from the ALU source and same-cycle read of a pending write.
    write_reg(2'd2, 8'h11);
    start_op(PASSB, 2'd0, 8'h5A, 3'd0, 1'b1);
    check("passb_flags", nzcv(), 4'b0000);
    i_ctrlBusSrc   = REG;
    i_ctrlRegBusSel = 2'd2;
    i_ctrlRegWr    = 1'b1;
    i_ctrlRegWrSel = 2'd3;
    i_ctrlBusSrc   = ALU;
    #1;
    check("wt_bus_alu", o_bus, 8'h5A);
    i_ctrlRegWrSel = 2'd2;
    cyc();
    // Now overwrite R2 from the override and read it on the bus in the same cycle.
    i_ctrlBusSrc   = REG;
    i_ctrlRegBusSel = 2'd2;
    i_ctrlRegWr    = 1'b0;
    #1;
    check("wt_r2_copy", o_bus, 8'h5A);
    i_ctrlBusSrc   = OVR;
    i_busOverride  = 8'hC3;
    i_ctrlRegWr    = 1'b1;
    i_ctrlRegWrSel = 2'd2;
    cyc();
    i_ctrlRegWr    = 1'b0;
    i_ctrlBusSrc   = REG;
    #1;
    check("wt_r2_new", o_bus, 8'hC3);
    // Write R2 from itself: bus shows the old value during the write cycle.
    i_ctrlRegWr    = 1'b1;
    i_ctrlRegWrSel = 2'd2;
    #1;
    check("wt_same_cycle_old", o_bus, 8'hC3);
    cyc();
    i_ctrlRegWr    = 1'b0;
    i_ctrlRegBusSel = 2'd3;
    #1;
    check("wt_r3_untouched", o_bus, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
